// File: rtl/tdc_pkg.sv
// Shared types and constants for the ring-oscillator TDC sequencing controller.
package tdc_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WARM = 2'd1,
        ST_CAL  = 2'd2,
        ST_RUN  = 2'd3
    } tdc_state_t;

    localparam int COUNT_W = 7;
    localparam int PHASE_N = 16;
    localparam int TDC_W   = 11;
    localparam int FINE_W  = 4;

    // Oscillator period with injection powered down (2.5 GHz), in femtoseconds.
    localparam int INJ_OFF_PERIOD_FS = 400000;

endpackage

// File: rtl/tdc_phase_dec.sv
// Thermometer-ring phase decoder: locates the single 0->1 edge of an
// 8-of-16 contiguous pattern and flags anything else as illegal.
module tdc_phase_dec
    import tdc_pkg::*;
(
    input  logic [PHASE_N-1:0] phase,
    output logic [FINE_W-1:0]  fine,
    output logic               illegal
);

    logic [4:0]        ones;
    logic [4:0]        rises;
    logic [FINE_W-1:0] idx;
    logic [FINE_W-1:0] idx_m1;

    // Exactly eight ones with exactly one rising edge implies one contiguous run.
    always_comb begin
        ones   = '0;
        rises  = '0;
        fine   = '0;
        idx    = '0;
        idx_m1 = '0;
        for (int k = 0; k < PHASE_N; k++) begin
            idx    = FINE_W'(k);
            idx_m1 = idx - 4'd1;
            ones   = ones + 5'(phase[idx]);
            if (phase[idx] && !phase[idx_m1]) begin
                rises = rises + 5'd1;
                fine  = idx;
            end
        end
        illegal = (ones != 5'd8) || (rises != 5'd1);
    end

endmodule

// File: rtl/tdc_ctrl.sv
// TDC power/calibration sequencer with a two-stage sample -> period-word pipeline.
//   state | meaning
//   OFF   | TDC and injection powered down, ctr_freq forced to 0
//   WARM  | TDC powered, injection off, settling for WARMUP_CYCLES
//   CAL   | injection off, 1 discarded + 2^CAL_LOG2 samples averaged into cal_ref
//   RUN   | injection on, period words streamed with tdc_valid
module tdc_ctrl
    import tdc_pkg::*;
#(
    parameter int WARMUP_CYCLES = 16,
    parameter int CAL_LOG2      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cal_req,
    input  logic [2:0]         cfg_ctr_freq,
    input  logic [COUNT_W-1:0] ripple_count,
    input  logic [PHASE_N-1:0] phase,
    output logic               pd,
    output logic               pd_inj,
    output logic [2:0]         ctr_freq,
    output logic [TDC_W-1:0]   tdc_out,
    output logic               tdc_valid,
    output logic               phase_err,
    output logic [TDC_W-1:0]   cal_ref,
    output logic               cal_done
);

    localparam int ACC_W  = TDC_W + CAL_LOG2;
    localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);
    localparam int CAL_W  = CAL_LOG2 + 1;

    tdc_state_t         state, state_nxt;
    logic [2:0]         cfg_q;
    logic [WARM_W-1:0]  warm_cnt;
    logic [CAL_W-1:0]   cal_cnt;
    logic               discard;
    logic [COUNT_W-1:0] cnt_s1, cnt_prev;
    logic [PHASE_N-1:0] phase_s1;
    logic [FINE_W-1:0]  fine_prev, fine_dec, fine_cur;
    logic               illegal;
    logic [COUNT_W-1:0] delta;
    logic [TDC_W-1:0]   word;
    logic [ACC_W-1:0]   acc, acc_sum;

    tdc_phase_dec u_phase_dec (
        .phase   (phase_s1),
        .fine    (fine_dec),
        .illegal (illegal)
    );

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = ST_OFF;
        end else begin
            case (state)
                ST_OFF:  state_nxt = ST_WARM;
                ST_WARM: if (warm_cnt == '0) state_nxt = ST_CAL;
                ST_CAL:  if (!discard && cal_cnt == '0) state_nxt = ST_RUN;
                ST_RUN:  if (cal_req) state_nxt = ST_WARM;
                default: state_nxt = ST_OFF;
            endcase
        end
    end

    // An illegal pattern reuses the previous fine code, so the word carries only the coarse delta.
    always_comb begin
        fine_cur = illegal ? fine_prev : fine_dec;
        delta    = cnt_s1 - cnt_prev;
        word     = {delta, {FINE_W{1'b0}}} + TDC_W'(fine_cur) - TDC_W'(fine_prev);
        acc_sum  = acc + ACC_W'(word);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_OFF;
            cfg_q     <= '0;
            warm_cnt  <= '0;
            cal_cnt   <= '0;
            discard   <= 1'b0;
            cnt_s1    <= '0;
            phase_s1  <= '0;
            cnt_prev  <= '0;
            fine_prev <= '0;
            acc       <= '0;
            pd        <= 1'b1;
            pd_inj    <= 1'b1;
            ctr_freq  <= '0;
            tdc_out   <= '0;
            tdc_valid <= 1'b0;
            phase_err <= 1'b0;
            cal_ref   <= '0;
            cal_done  <= 1'b0;
        end else begin
            state    <= state_nxt;
            discard  <= (state_nxt != state) && (state_nxt == ST_CAL || state_nxt == ST_RUN);
            pd       <= (state == ST_OFF);
            pd_inj   <= (state != ST_RUN);
            ctr_freq <= (state == ST_OFF) ? 3'd0 : cfg_q;
            cnt_s1   <= ripple_count;
            phase_s1 <= phase;

            if (state == ST_OFF && state_nxt == ST_WARM)
                cfg_q <= cfg_ctr_freq;

            if (state_nxt == ST_WARM && state != ST_WARM)
                warm_cnt <= WARM_W'(WARMUP_CYCLES - 1);
            else if (state == ST_WARM && warm_cnt != '0)
                warm_cnt <= warm_cnt - 1'b1;

            if (state != ST_OFF) begin
                cnt_prev  <= cnt_s1;
                fine_prev <= fine_cur;
                tdc_out   <= word;
                phase_err <= illegal;
                tdc_valid <= (state == ST_RUN) && !discard;
            end else begin
                phase_err <= 1'b0;
                tdc_valid <= 1'b0;
            end

            if (state_nxt == ST_CAL && state != ST_CAL) begin
                acc     <= '0;
                cal_cnt <= CAL_W'((1 << CAL_LOG2) - 1);
            end else if (state == ST_CAL && !discard) begin
                acc     <= acc_sum;
                cal_cnt <= cal_cnt - 1'b1;
            end

            if (state == ST_CAL && state_nxt == ST_RUN) begin
                cal_ref  <= acc_sum[ACC_W-1:CAL_LOG2];
                cal_done <= 1'b1;
            end else if (state == ST_RUN && state_nxt == ST_WARM) begin
                cal_done <= 1'b0;
            end
        end
    end

endmodule
